cr16_alu_bist: RTL and testbench

//  On-chip built-in self-test driver for cr16_alu: issues ADD then ADDU operations on
//  the ALU operand/opcode inputs and checks O_C/O_STATUS against an internal golden model.

---
 rtl/cr16_pkg.sv | 39 +++
 rtl/cr16_alu_bist_lfsr.sv | 29 ++
 rtl/cr16_alu_bist.sv | 198 +++++++++++++++++++
 tb/tb_cr16_alu_bist.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// Shared constants, state encoding and vector payload for the cr16 ALU self-test.
package cr16_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned STAT_W = 5;
   localparam int unsigned OPC_W  = 4;
   localparam int unsigned LFSR_W = 32;

   localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [OPC_W-1:0] OP_ADDU = 4'b0001;

   localparam int unsigned STAT_N = 4;
   localparam int unsigned STAT_Z = 3;
   localparam int unsigned STAT_F = 2;
   localparam int unsigned STAT_L = 1;
   localparam int unsigned STAT_C = 0;

   localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h80200003;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_e;

   typedef struct packed {
      logic              vld;
      logic [OPC_W-1:0]  opcode;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } bist_vec_t;

   // Right-shifting Galois step
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
   endfunction

endpackage

// File: rtl/cr16_alu_bist_lfsr.sv
// 32-bit Galois LFSR with seed load; o_state_c shows the value consumed this cycle.
module cr16_alu_bist_lfsr
   import cr16_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 32'h1
) (
   input  logic              i_clk,
   input  logic              i_nreset,
   input  logic              i_load,
   input  logic              i_adv,
   output logic [LFSR_W-1:0] o_state_c
);

   logic [LFSR_W-1:0] r_state;

   // A load presents the seed immediately so the first vector of a run is the seed itself
   assign o_state_c = i_load ? SEED : r_state;

   always_ff @(posedge i_clk or negedge i_nreset) begin
      if (!i_nreset) begin
         r_state <= SEED;
      end else if (i_adv) begin
         r_state <= lfsr_next(o_state_c);
      end else if (i_load) begin
         r_state <= SEED;
      end
   end

endmodule

// File: rtl/cr16_alu_bist.sv
// Self-test driver for cr16_alu: issues ADD then ADDU vectors and checks results.
// Optional CR16_ALU_BIST_CAPTURE_EN adds first-mismatch capture ports.
module cr16_alu_bist
   import cr16_pkg::*;
#(
   parameter int unsigned       N_VECTORS   = 256,
   parameter int unsigned       ALU_LATENCY = 1,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = 32'hACE11234
) (
   input  logic              I_CLK,
   input  logic              I_NRESET,
   input  logic              I_START,
   output logic              O_BUSY,
   output logic              O_DONE,
   output logic              O_PASS,
   output logic [15:0]       O_ERR_COUNT,
   output logic [DATA_W-1:0] O_ALU_A,
   output logic [DATA_W-1:0] O_ALU_B,
   output logic [OPC_W-1:0]  O_ALU_OPCODE,
   output logic              O_ALU_ENABLE,
   input  logic [DATA_W-1:0] I_ALU_C,
   input  logic [STAT_W-1:0] I_ALU_STATUS
`ifdef CR16_ALU_BIST_CAPTURE_EN
   ,
   output logic [OPC_W-1:0]  O_FAIL_OPCODE,
   output logic [DATA_W-1:0] O_FAIL_A,
   output logic [DATA_W-1:0] O_FAIL_B,
   output logic [DATA_W-1:0] O_FAIL_C,
   output logic [STAT_W-1:0] O_FAIL_STATUS
`endif
);

   localparam int unsigned       CNT_W    = $clog2(2 * N_VECTORS) + 1;
   localparam int unsigned       DRN_W    = $clog2(ALU_LATENCY + 1);
   localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 32'h1 : LFSR_SEED;

   bist_state_e       r_state, w_state_nxt;
   logic              w_accept, w_issue;
   logic [OPC_W-1:0]  w_opcode_nxt;
   logic [CNT_W-1:0]  r_vec_cnt;
   logic [DRN_W-1:0]  r_drain_cnt;
   logic [LFSR_W-1:0] w_lfsr;
   logic              r_vec_vld, r_busy, r_done, r_pass, r_enable;
   logic [15:0]       r_err_count, w_err_nxt;
   logic [DATA_W-1:0] r_a, r_b;
   logic [OPC_W-1:0]  r_opcode;
   bist_vec_t         r_pipe [ALU_LATENCY];
   bist_vec_t         w_stage0, w_tok;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_res;
   logic              w_zero, w_ovf, w_diff_add, w_diff_addu, w_mism;
   logic              w_busy_nxt;

   cr16_alu_bist_lfsr #(.SEED(SEED_EFF)) u_lfsr (
      .i_clk     (I_CLK),
      .i_nreset  (I_NRESET),
      .i_load    (w_accept),
      .i_adv     (w_issue),
      .o_state_c (w_lfsr)
   );

   // Next state; the accepting cycle already issues vector 0
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_issue      = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (I_START) begin
               w_accept    = 1'b1;
               w_issue     = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_issue = 1'b1;
            if (r_vec_cnt == CNT_W'(2 * N_VECTORS - 1)) w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_drain_cnt == DRN_W'(ALU_LATENCY)) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      w_opcode_nxt = (!w_accept && (r_vec_cnt >= CNT_W'(N_VECTORS))) ? OP_ADDU : OP_ADD;
      w_busy_nxt   = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN);
   end

   // Golden model at the pipe output
   assign w_tok       = r_pipe[ALU_LATENCY-1];
   assign w_sum       = (DATA_W+1)'(w_tok.a) + (DATA_W+1)'(w_tok.b);
   assign w_res       = w_sum[DATA_W-1:0];
   assign w_zero      = (w_res == '0);
   assign w_ovf       = (w_tok.a[DATA_W-1] == w_tok.b[DATA_W-1]) && (w_res[DATA_W-1] != w_tok.a[DATA_W-1]);
   assign w_diff_add  = (I_ALU_C != w_res) || (I_ALU_STATUS[STAT_N] != w_res[DATA_W-1]) ||
                        (I_ALU_STATUS[STAT_Z] != w_zero) || (I_ALU_STATUS[STAT_F] != w_ovf) ||
                        I_ALU_STATUS[STAT_C];
   assign w_diff_addu = (I_ALU_C != w_res) || (I_ALU_STATUS[STAT_Z] != w_zero) ||
                        (I_ALU_STATUS[STAT_C] != w_sum[DATA_W]) || I_ALU_STATUS[STAT_F];
   assign w_mism      = w_tok.vld && ((w_tok.opcode == OP_ADDU) ? w_diff_addu : w_diff_add);
   assign w_err_nxt   = w_accept ? 16'h0 :
                        (w_mism && (r_err_count != 16'hFFFF)) ? r_err_count + 16'd1 : r_err_count;

   always_comb begin
      w_stage0        = '0;
      w_stage0.vld    = r_vec_vld;
      w_stage0.opcode = r_opcode;
      w_stage0.a      = r_a;
      w_stage0.b      = r_b;
   end

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         r_state     <= ST_IDLE;
         r_vec_cnt   <= '0;
         r_drain_cnt <= '0;
         r_vec_vld   <= 1'b0;
         r_busy      <= 1'b0;
         r_enable    <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_count <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_opcode    <= '0;
         for (int unsigned j = 0; j < ALU_LATENCY; j++) r_pipe[j] <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_vec_vld   <= w_issue;
         r_busy      <= w_busy_nxt;
         r_enable    <= w_busy_nxt;
         r_err_count <= w_err_nxt;
         r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DRN_W'(1) : '0;
         if (w_issue) begin
            r_a       <= w_lfsr[LFSR_W-1:DATA_W];
            r_b       <= w_lfsr[DATA_W-1:0];
            r_opcode  <= w_opcode_nxt;
            r_vec_cnt <= w_accept ? CNT_W'(1) : r_vec_cnt + CNT_W'(1);
         end
         if (w_accept) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
         end else if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE)) begin
            r_done <= 1'b1;
            r_pass <= (w_err_nxt == 16'h0);
         end
         r_pipe[0] <= w_stage0;
         for (int unsigned j = 1; j < ALU_LATENCY; j++) r_pipe[j] <= r_pipe[j-1];
      end
   end

   assign O_BUSY       = r_busy;
   assign O_DONE       = r_done;
   assign O_PASS       = r_pass;
   assign O_ERR_COUNT  = r_err_count;
   assign O_ALU_A      = r_a;
   assign O_ALU_B      = r_b;
   assign O_ALU_OPCODE = r_opcode;
   assign O_ALU_ENABLE = r_enable;

`ifdef CR16_ALU_BIST_CAPTURE_EN
   logic [OPC_W-1:0]  r_fail_opcode;
   logic [DATA_W-1:0] r_fail_a, r_fail_b, r_fail_c;
   logic [STAT_W-1:0] r_fail_status;

   // Error count still zero means this is the first mismatch of the run
   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         r_fail_opcode <= '0;
         r_fail_a      <= '0;
         r_fail_b      <= '0;
         r_fail_c      <= '0;
         r_fail_status <= '0;
      end else if (w_accept) begin
         r_fail_opcode <= '0;
         r_fail_a      <= '0;
         r_fail_b      <= '0;
         r_fail_c      <= '0;
         r_fail_status <= '0;
      end else if (w_mism && (r_err_count == 16'h0)) begin
         r_fail_opcode <= w_tok.opcode;
         r_fail_a      <= w_tok.a;
         r_fail_b      <= w_tok.b;
         r_fail_c      <= I_ALU_C;
         r_fail_status <= I_ALU_STATUS;
      end
   end

   assign O_FAIL_OPCODE = r_fail_opcode;
   assign O_FAIL_A      = r_fail_a;
   assign O_FAIL_B      = r_fail_b;
   assign O_FAIL_C      = r_fail_c;
   assign O_FAIL_STATUS = r_fail_status;
`else
   logic w_unused_l;
   assign w_unused_l = I_ALU_STATUS[STAT_L];
`endif

endmodule

// File: tb/tb_cr16_alu_bist.sv
// Bench for cr16_alu_bist: behavioural ALU with fault modes and a vector/error reference model.
module tb_cr16_alu_bist;

   localparam int NV  = 16;
   localparam int LAT = 1;
   localparam logic [31:0] MASK = 32'h80200003;

   logic        clk = 1'b0;
   logic        rst_n, start;
   logic        busy, done, pass, en;
   logic [15:0] errc, a, b, alu_c;
   logic [3:0]  op;
   logic [4:0]  alu_st;
`ifdef CR16_ALU_BIST_CAPTURE_EN
   logic [3:0]  f_op;
   logic [15:0] f_a, f_b, f_c;
   logic [4:0]  f_st;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int fault_mode = 0;
   int alu_idx = 0;
   int rnd_cnt = 0;
   logic [15:0] ma [2*NV];
   logic [15:0] mb [2*NV];

   cr16_alu_bist #(.N_VECTORS(NV), .ALU_LATENCY(LAT), .LFSR_SEED(32'hACE11234)) dut (
      .I_CLK(clk), .I_NRESET(rst_n), .I_START(start),
      .O_BUSY(busy), .O_DONE(done), .O_PASS(pass), .O_ERR_COUNT(errc),
      .O_ALU_A(a), .O_ALU_B(b), .O_ALU_OPCODE(op), .O_ALU_ENABLE(en),
      .I_ALU_C(alu_c), .I_ALU_STATUS(alu_st)
`ifdef CR16_ALU_BIST_CAPTURE_EN
      , .O_FAIL_OPCODE(f_op), .O_FAIL_A(f_a), .O_FAIL_B(f_b), .O_FAIL_C(f_c), .O_FAIL_STATUS(f_st)
`endif
   );

   always #5 clk = ~clk;

   // One-cycle-latency ALU; mode 1: ADDU carry stuck 0, 2: result 0, 3: random corruption
   always @(posedge clk) begin : alu
      logic [16:0] s;
      logic [15:0] r, c;
      logic [4:0]  st;
      bit          is_add, counted;
      int          pick;
      s  = {1'b0, a} + {1'b0, b};
      r  = s[15:0];
      c  = r;
      is_add = (op == 4'b0000);
      st[4] = r[15];
      st[3] = (r == 16'h0);
      st[2] = is_add ? ((a[15] == b[15]) && (r[15] != a[15])) : 1'b0;
      st[1] = ($signed(a) < $signed(b));
      st[0] = is_add ? 1'b0 : s[16];
      if (fault_mode == 1 && !is_add) st[0] = 1'b0;
      if (fault_mode == 2) c = 16'h0;
      counted = 1'b0;
      if (busy) begin
         if (alu_idx == 0) rnd_cnt = 0;
         if (fault_mode == 3 && alu_idx < 2*NV) begin
            pick = $urandom_range(0, 3);
            case (pick)
               1: begin c = c ^ 16'($urandom_range(1, 16'hFFFF)); st[3] = ~st[3]; counted = 1'b1; end
               2: st[1] = ~st[1];
               3: begin st[4] = ~st[4]; counted = is_add; end
               default: ;
            endcase
            if (counted) rnd_cnt++;
         end
         alu_idx++;
      end else begin
         alu_idx = 0;
      end
      alu_c  <= c;
      alu_st <= st;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int model_err(input int mode);
      int n = 0;
      for (int k = 0; k < 2*NV; k++) begin
         int sum = int'(ma[k]) + int'(mb[k]);
         if (mode == 1 && k >= NV && sum > 65535) n++;
         if (mode == 2 && (sum & 32'hFFFF) != 0) n++;
      end
      return n;
   endfunction

   // Start a run and follow it; rst_at > 0 pulls reset at that busy cycle
   task automatic run_case(input int mode, input bit glitch, input int rst_at,
                           output int len, output int vmis, output logic done0,
                           output logic [15:0] a0, output logic [15:0] b0);
      fault_mode = mode;
      len = 0; vmis = 0; done0 = 1'bx; a0 = 'x; b0 = 'x;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      start = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) begin
            if (len == 0) begin done0 = done; a0 = a; b0 = b; end
            if (len < 2*NV && (a !== ma[len] || b !== mb[len] || op !== ((len < NV) ? 4'd0 : 4'd1))) vmis++;
            len++;
            if (glitch && (len == 5 || len == 20)) start = 1'b1;
            if (rst_at > 0 && len == rst_at) begin
               rst_n = 1'b0;
               #1;
               chk("reset_mid_run", {busy, done, pass, en, errc, a, b, op}, 64'h0);
               @(negedge clk);
               chk("reset_held", {busy, done, pass, en, errc, a, b, op}, 64'h0);
               rst_n = 1'b1;
               break;
            end
         end else if (len > 0) begin
            break;
         end
      end
   endtask

   typedef struct {
      int mode;
      bit glitch;
      int exp_len;
      int exp_err;
   } vec_t;

   initial begin : main
      vec_t tbl [7];
      int len, vmis, exp;
      logic d0;
      logic [15:0] a0, b0;
      logic [31:0] s;

      s = 32'hACE11234;
      for (int k = 0; k < 2*NV; k++) begin
         ma[k] = s[31:16];
         mb[k] = s[15:0];
         s = (s >> 1) ^ (s[0] ? MASK : 32'h0);
      end
      tbl[0] = '{0, 1'b0, 2*NV+LAT, 0};
      tbl[1] = '{1, 1'b0, 2*NV+LAT, model_err(1)};
      tbl[2] = '{2, 1'b0, 2*NV+LAT, 32};
      tbl[3] = '{2, 1'b0, 2*NV+LAT, model_err(2)};
      tbl[4] = '{0, 1'b1, 2*NV+LAT, 0};
      tbl[5] = '{3, 1'b0, 2*NV+LAT, -1};
      tbl[6] = '{3, 1'b1, 2*NV+LAT, -1};

      rst_n = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {busy, done, pass, en, errc, a, b, op}, 64'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_no_start", {busy, done, pass, en, errc, a, b, op}, 64'h0);

      for (int i = 0; i < 7; i++) begin
         run_case(tbl[i].mode, tbl[i].glitch, 0, len, vmis, d0, a0, b0);
         exp = (tbl[i].exp_err < 0) ? rnd_cnt : tbl[i].exp_err;
         chk("busy_len", 64'(len), 64'(tbl[i].exp_len));
         chk("vec_seq", 64'(vmis), 64'h0);
         chk("first_vec", {a0, b0}, 64'hACE11234);
         chk("done_cleared", 64'(d0), 64'h0);
         chk("done", 64'(done), 64'h1);
         chk("pass", 64'(pass), 64'(exp == 0));
         chk("err_count", 64'(errc), 64'(exp));
         chk("enable_off", {en, busy}, 64'h0);
         chk("hold_operands", {a, b}, {32'h0, ma[2*NV-1], mb[2*NV-1]});
`ifdef CR16_ALU_BIST_CAPTURE_EN
         if (tbl[i].mode == 1 && exp > 0) begin
            chk("fail_opcode", 64'(f_op), 64'h1);
            chk("fail_status_c", 64'(f_st[0]), 64'h0);
         end
`endif
      end

      // Reset mid-run, then an uninterrupted rerun must match the model
      run_case(1, 1'b0, 10, len, vmis, d0, a0, b0);
      chk("rst_vec_seq", 64'(vmis), 64'h0);
      run_case(1, 1'b0, 0, len, vmis, d0, a0, b0);
      chk("rst_rerun_len", 64'(len), 64'(2*NV+LAT));
      chk("rst_rerun_seq", 64'(vmis), 64'h0);
      chk("rst_rerun_err", 64'(errc), 64'(model_err(1)));
      chk("rst_rerun_done", {done, pass}, {62'h0, 1'b1, model_err(1) == 0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
